// File: rtl/ob_pkg.sv
// -----------------------------------------------------------------------------
// ob_pkg
// Shared order-book types: command uid, opcode encoding, operand fields and the
// packed command word carried from the host through ingress into the book.
// Also provides is_legal_opcode(), the screen used by the ingress stage, and
// the default ingress FIFO depth.
// -----------------------------------------------------------------------------
package ob_pkg;

   localparam int OB_CMD_INGRESS_DEPTH_DFLT = 8;

   localparam int UID_W   = 8;
   localparam int QTY_W   = 16;
   localparam int PRICE_W = 16;

   typedef logic [UID_W-1:0] uid_t;

   // Only these encodings are meaningful to the book; every other 4-bit value
   // is an illegal opcode and is screened out at ingress.
   typedef enum logic [3:0] {
      Op_Nop       = 4'h0,
      Op_QryBidAsk = 4'h1,
      Op_Buy       = 4'h2,
      Op_Sell      = 4'h3
   } opcode_t;

   typedef struct packed {
      logic [QTY_W-1:0]   qty;
      logic [PRICE_W-1:0] price;
   } oprand_t;

   typedef struct packed {
      uid_t    uid;
      opcode_t opcode;
      oprand_t oprand;
   } cmd_t;

   function automatic logic is_legal_opcode(input opcode_t op);
      case (op)
         Op_Nop, Op_QryBidAsk, Op_Buy, Op_Sell: return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

endpackage : ob_pkg

// File: rtl/ob_cmd_fifo.sv
// -----------------------------------------------------------------------------
// ob_cmd_fifo
// Generic synchronous FIFO with registered pointers and a combinational head.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
//
// Ports:
//   clk    in   clock, posedge
//   rst    in   asynchronous reset, active-low
//   push   in   write wdata this cycle (ignored when full)
//   wdata  in   WIDTH-bit write data
//   pop    in   advance the read pointer this cycle (ignored when empty)
//   rdata  out  head entry (valid while !empty)
//   full   out  DEPTH entries held
//   empty  out  no entries held
//   count  out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module ob_cmd_fifo
   import ob_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = OB_CMD_INGRESS_DEPTH_DFLT,
   localparam int AW    = $clog2(DEPTH),
   localparam int PW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [PW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wp;
   logic [PW-1:0]    rp;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values
         // regardless of statement order; blocking here would race with readers.
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which
   // entries are valid, and a reset on the array would cost a flop per bit.
   always_ff @(posedge clk) begin
      if (do_push) mem[wp[AW-1:0]] <= wdata;
   end

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign count = wp - rp;
   assign rdata = mem[rp[AW-1:0]];

endmodule : ob_cmd_fifo

// File: rtl/ob_cmd_ingress.sv
// -----------------------------------------------------------------------------
// ob_cmd_ingress
// Command ingress in front of the order book. Host commands arrive on a
// valid/ready handshake, illegal opcodes are discarded (reported on a one-cycle
// drop pulse), legal ones are queued in order and issued to the book at most
// one per cycle whenever the book's registered cmd_full_r is low. All
// book-facing outputs are registered.
//
// Optional build macro: OB_CMD_INGRESS_STATS_EN
//   adds saturating accepted/issued/dropped counters and an occupancy
//   high-water mark.
//
// Ports:
//   clk              in   clock, posedge
//   rst              in   asynchronous reset, active-low
//   in_vld           in   host command valid
//   in_cmd           in   host command (cmd_t)
//   in_rdy           out  registered !full; low in reset
//   cmd_vld_r        out  command valid to the book
//   cmd_r            out  command to the book, held when cmd_vld_r is low
//   cmd_full_r       in   book back-pressure
//   drop_vld_r       out  one-cycle pulse per discarded illegal command
//   drop_uid_r       out  uid of the last discarded command
//   busy             out  queue non-empty or cmd_vld_r high
//   stat_accepted_r  out  (stats) accepted handshakes, saturating
//   stat_issued_r    out  (stats) commands issued, saturating
//   stat_dropped_r   out  (stats) commands dropped, saturating
//   stat_hwm_r       out  (stats) peak queue occupancy since reset
// -----------------------------------------------------------------------------
module ob_cmd_ingress
   import ob_pkg::*;
#(
   parameter int DEPTH = OB_CMD_INGRESS_DEPTH_DFLT,
   parameter int CNT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_vld,
   input  cmd_t                    in_cmd,
   output logic                    in_rdy,
   output logic                    cmd_vld_r,
   output cmd_t                    cmd_r,
   input  logic                    cmd_full_r,
   output logic                    drop_vld_r,
   output uid_t                    drop_uid_r,
   output logic                    busy
`ifdef OB_CMD_INGRESS_STATS_EN
   ,
   output logic [CNT_W-1:0]        stat_accepted_r,
   output logic [CNT_W-1:0]        stat_issued_r,
   output logic [CNT_W-1:0]        stat_dropped_r,
   output logic [$clog2(DEPTH):0]  stat_hwm_r
`endif
);

   localparam int PW = $clog2(DEPTH) + 1;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (CNT_W < 1)) begin : g_bad_param
      $error("ob_cmd_ingress: DEPTH must be a power of 2 >= 2 and CNT_W >= 1");
   end

   cmd_t          head;
   logic          fifo_full;
   logic          fifo_empty;
   logic [PW-1:0] occ;
   logic [PW-1:0] occ_next;

   logic          accept;
   logic          push;
   logic          drop;
   logic          pop;

   // Screening and issue decisions for this edge.
   // NOTE: every always_comb output gets a default first so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      accept = 1'b0;
      push   = 1'b0;
      drop   = 1'b0;
      pop    = 1'b0;
      if (in_vld && in_rdy) begin
         accept = 1'b1;
         push   = is_legal_opcode(in_cmd.opcode);
         drop   = ~is_legal_opcode(in_cmd.opcode);
      end
      // The pop looks only at the pre-edge queue, so a command pushed into an
      // empty queue waits one cycle rather than bypassing to the book.
      if (!fifo_empty && !cmd_full_r) pop = 1'b1;
   end

   // Occupancy after this edge; in_rdy is registered from it so it is low
   // exactly while the queue holds DEPTH entries.
   assign occ_next = occ + PW'(push) - PW'(pop);

   ob_cmd_fifo #(
      .WIDTH ($bits(cmd_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (in_cmd),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (occ)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_rdy     <= 1'b0;
         cmd_vld_r  <= 1'b0;
         cmd_r      <= '0;
         drop_vld_r <= 1'b0;
         drop_uid_r <= '0;
      end else begin
         in_rdy     <= (occ_next != PW'(DEPTH));
         cmd_vld_r  <= pop;
         if (pop)  cmd_r      <= head;
         drop_vld_r <= drop;
         if (drop) drop_uid_r <= in_cmd.uid;
      end
   end

   assign busy = ~fifo_empty | cmd_vld_r;

`ifdef OB_CMD_INGRESS_STATS_EN
   // Event counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_accepted_r <= '0;
         stat_issued_r   <= '0;
         stat_dropped_r  <= '0;
         stat_hwm_r      <= '0;
      end else begin
         if (accept && (stat_accepted_r != '1)) stat_accepted_r <= stat_accepted_r + 1'b1;
         if (pop    && (stat_issued_r   != '1)) stat_issued_r   <= stat_issued_r + 1'b1;
         if (drop   && (stat_dropped_r  != '1)) stat_dropped_r  <= stat_dropped_r + 1'b1;
         // Tracked against the post-edge occupancy so the mark is current.
         if (occ_next > stat_hwm_r) stat_hwm_r <= occ_next;
      end
   end
`else
   // No statistics logic in this build; the command path above is unchanged.
`endif

endmodule : ob_cmd_ingress

// File: tb/tb_ob_cmd_ingress.sv
// -----------------------------------------------------------------------------
// tb_ob_cmd_ingress
// Directed self-checking bench for ob_cmd_ingress. Inputs change 1 ns after
// each rising edge and outputs are sampled at the same point, so every value
// read reflects the state left by the preceding edge.
// -----------------------------------------------------------------------------
module tb_ob_cmd_ingress;
   import ob_pkg::*;

   localparam int DEPTH = 8;
   localparam int CNT_W = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_vld = 1'b0;
   cmd_t in_cmd = '0;
   logic in_rdy;
   logic cmd_vld_r;
   cmd_t cmd_r;
   logic cmd_full_r = 1'b0;
   logic drop_vld_r;
   uid_t drop_uid_r;
   logic busy;
`ifdef OB_CMD_INGRESS_STATS_EN
   logic [CNT_W-1:0]        stat_accepted_r;
   logic [CNT_W-1:0]        stat_issued_r;
   logic [CNT_W-1:0]        stat_dropped_r;
   logic [$clog2(DEPTH):0]  stat_hwm_r;
`endif

   int tests  = 0;
   int failed = 0;

   // Monitor state: everything the book sees, drop pulses, and any issue that
   // followed an edge where cmd_full_r was high.
   uid_t issued_q[$];
   int   drop_cnt = 0;
   int   bp_viol  = 0;
   logic full_sampled = 1'b0;

   ob_cmd_ingress #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_vld     (in_vld),
      .in_cmd     (in_cmd),
      .in_rdy     (in_rdy),
      .cmd_vld_r  (cmd_vld_r),
      .cmd_r      (cmd_r),
      .cmd_full_r (cmd_full_r),
      .drop_vld_r (drop_vld_r),
      .drop_uid_r (drop_uid_r),
      .busy       (busy)
`ifdef OB_CMD_INGRESS_STATS_EN
      ,
      .stat_accepted_r (stat_accepted_r),
      .stat_issued_r   (stat_issued_r),
      .stat_dropped_r  (stat_dropped_r),
      .stat_hwm_r      (stat_hwm_r)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) full_sampled <= cmd_full_r;

   always @(negedge clk) begin
      if (cmd_vld_r) begin
         issued_q.push_back(cmd_r.uid);
         if (full_sampled) bp_viol <= bp_viol + 1;
      end
      if (drop_vld_r) drop_cnt <= drop_cnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic cmd_t mk(input uid_t uid, input opcode_t op,
                               input logic [15:0] qty, input logic [15:0] price);
      cmd_t c;
      c.uid          = uid;
      c.opcode       = op;
      c.oprand.qty   = qty;
      c.oprand.price = price;
      return c;
   endfunction

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b0;
      in_vld = 1'b0;
      cmd_full_r = 1'b0;
      repeat (2) step();
      tests++; if (in_rdy !== 1'b0) begin failed++; $display("FAIL reset_in_rdy: got %b, expected 0", in_rdy); end
      tests++; if (cmd_vld_r !== 1'b0) begin failed++; $display("FAIL reset_cmd_vld: got %b, expected 0", cmd_vld_r); end
      tests++; if (cmd_r !== '0) begin failed++; $display("FAIL reset_cmd_r: got %h, expected 0", cmd_r); end
      tests++; if (drop_vld_r !== 1'b0) begin failed++; $display("FAIL reset_drop_vld: got %b, expected 0", drop_vld_r); end
      tests++; if (drop_uid_r !== '0) begin failed++; $display("FAIL reset_drop_uid: got %h, expected 0", drop_uid_r); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      rst = 1'b1;
      step();
      tests++; if (in_rdy !== 1'b1) begin failed++; $display("FAIL reset_release_in_rdy: got %b, expected 1", in_rdy); end
   endtask

   // Accept on edge A; the pop at edge A+1 raises cmd_vld_r for one cycle.
   task automatic test_latency();
      cmd_full_r = 1'b0;
      in_cmd = mk(8'd5, Op_Buy, 16'd10, 16'h0123);
      in_vld = 1'b1;
      step();
      in_vld = 1'b0;
      tests++; if (cmd_vld_r !== 1'b0) begin failed++; $display("FAIL lat_early_vld: got %b, expected 0", cmd_vld_r); end
      tests++; if (busy !== 1'b1) begin failed++; $display("FAIL lat_busy: got %b, expected 1", busy); end
      step();
      tests++; if (cmd_vld_r !== 1'b1) begin failed++; $display("FAIL lat_vld: got %b, expected 1", cmd_vld_r); end
      tests++; if (cmd_r.uid !== 8'd5) begin failed++; $display("FAIL lat_uid: got %h, expected 05", cmd_r.uid); end
      tests++; if (cmd_r.opcode !== Op_Buy) begin failed++; $display("FAIL lat_opcode: got %h, expected %h", cmd_r.opcode, Op_Buy); end
      tests++; if (cmd_r.oprand !== {16'd10, 16'h0123}) begin failed++; $display("FAIL lat_oprand: got %h, expected %h", cmd_r.oprand, {16'd10, 16'h0123}); end
      step();
      tests++; if (cmd_vld_r !== 1'b0) begin failed++; $display("FAIL lat_single_pulse: got %b, expected 0", cmd_vld_r); end
      tests++; if (cmd_r.uid !== 8'd5) begin failed++; $display("FAIL lat_hold: got %h, expected 05", cmd_r.uid); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL lat_idle: got %b, expected 0", busy); end
   endtask

   // Fill under back-pressure, hold a 9th command while full, then drain: the
   // release edge pops but cannot push, the next edge accepts uid 9, and 1..9
   // issue on nine consecutive cycles.
   task automatic test_back_to_back();
      int early = 0;
      cmd_full_r = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         in_cmd = mk(uid_t'(i), Op_Buy, 16'(i), 16'h0100);
         in_vld = 1'b1;
         step();
         if (cmd_vld_r !== 1'b0) early++;
      end
      tests++; if (in_rdy !== 1'b0) begin failed++; $display("FAIL fill_in_rdy: got %b, expected 0", in_rdy); end
      in_cmd = mk(8'd9, Op_Sell, 16'd9, 16'h0200);
      repeat (2) begin
         step();
         if (cmd_vld_r !== 1'b0) early++;
      end
      tests++; if (in_rdy !== 1'b0) begin failed++; $display("FAIL full_hold_in_rdy: got %b, expected 0", in_rdy); end
      tests++; if (early !== 0) begin failed++; $display("FAIL fill_no_issue: got %0d issues, expected 0", early); end
      cmd_full_r = 1'b0;
      for (int i = 1; i <= DEPTH + 1; i++) begin
         step();
         if (i == 1) begin
            tests++; if (in_rdy !== 1'b1) begin failed++; $display("FAIL drain_in_rdy: got %b, expected 1", in_rdy); end
         end
         if (i == 2) in_vld = 1'b0;
         tests++;
         if (cmd_vld_r !== 1'b1 || cmd_r.uid !== uid_t'(i)) begin
            failed++;
            $display("FAIL drain_seq[%0d]: got vld=%b uid=%h, expected vld=1 uid=%h", i, cmd_vld_r, cmd_r.uid, uid_t'(i));
         end
      end
      step();
      tests++; if (cmd_vld_r !== 1'b0) begin failed++; $display("FAIL drain_end: got %b, expected 0", cmd_vld_r); end
   endtask

   task automatic test_drop();
      int d0;
      cmd_full_r = 1'b0;
      issued_q.delete();
      d0 = drop_cnt;
      in_vld = 1'b1;
      in_cmd = mk(8'h10, Op_Sell, 16'd1, 16'h0300);
      step();
      tests++; if (drop_vld_r !== 1'b0) begin failed++; $display("FAIL drop_pre: got %b, expected 0", drop_vld_r); end
      in_cmd = mk(8'h3A, opcode_t'(4'hF), 16'd2, 16'h0301);
      step();
      tests++; if (drop_vld_r !== 1'b1) begin failed++; $display("FAIL drop_pulse: got %b, expected 1", drop_vld_r); end
      tests++; if (drop_uid_r !== 8'h3A) begin failed++; $display("FAIL drop_uid: got %h, expected 3a", drop_uid_r); end
      in_cmd = mk(8'h11, Op_Sell, 16'd3, 16'h0302);
      step();
      in_vld = 1'b0;
      tests++; if (drop_vld_r !== 1'b0) begin failed++; $display("FAIL drop_one_cycle: got %b, expected 0", drop_vld_r); end
      repeat (4) step();
      tests++; if (drop_cnt - d0 !== 1) begin failed++; $display("FAIL drop_count: got %0d, expected 1", drop_cnt - d0); end
      tests++;
      if (issued_q.size() != 2 || issued_q[0] !== 8'h10 || issued_q[1] !== 8'h11) begin
         failed++;
         $display("FAIL drop_forwarded: got %0d cmds %p, expected 2 cmds 10,11", issued_q.size(), issued_q);
      end
      // Op_Nop is legal and must reach the book.
      d0 = drop_cnt;
      in_cmd = mk(8'h20, Op_Nop, 16'd0, 16'd0);
      in_vld = 1'b1;
      step();
      in_vld = 1'b0;
      step();
      tests++;
      if (cmd_vld_r !== 1'b1 || cmd_r.uid !== 8'h20 || cmd_r.opcode !== Op_Nop) begin
         failed++;
         $display("FAIL nop_forward: got vld=%b uid=%h op=%h, expected vld=1 uid=20 op=0", cmd_vld_r, cmd_r.uid, cmd_r.opcode);
      end
      step();
      tests++; if (drop_cnt - d0 !== 0) begin failed++; $display("FAIL nop_not_dropped: got %0d drops, expected 0", drop_cnt - d0); end
   endtask

   // Host pushes every cycle it can while cmd_full_r toggles each cycle.
   task automatic test_toggle_bp();
      int   sent = 0;
      int   cyc  = 0;
      int   v0;
      int   bad  = 0;
      logic rdy;
      uid_t exp_q[$];
      issued_q.delete();
      v0 = bp_viol;
      cmd_full_r = 1'b0;
      while (sent < 16 && cyc < 400) begin
         in_cmd = mk(uid_t'(8'h40 + sent), (sent % 2 == 1) ? Op_Buy : Op_Sell, 16'(sent), 16'h0400);
         in_vld = 1'b1;
         rdy = in_rdy;
         step();
         cyc++;
         cmd_full_r = ~cmd_full_r;
         if (rdy) begin
            exp_q.push_back(uid_t'(8'h40 + sent));
            sent++;
         end
      end
      in_vld = 1'b0;
      cmd_full_r = 1'b0;
      repeat (DEPTH + 4) step();
      tests++; if (sent !== 16) begin failed++; $display("FAIL toggle_timeout: got %0d sent, expected 16", sent); end
      if (issued_q.size() != exp_q.size()) bad++;
      else foreach (exp_q[i]) if (issued_q[i] !== exp_q[i]) bad++;
      tests++; if (bad !== 0) begin failed++; $display("FAIL toggle_order: got %p, expected %p", issued_q, exp_q); end
      tests++; if (bp_viol - v0 !== 0) begin failed++; $display("FAIL toggle_bp: got %0d issues under full, expected 0", bp_viol - v0); end
   endtask

   task automatic test_reset_mid();
      cmd_full_r = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_cmd = mk(uid_t'(8'h60 + i), Op_Buy, 16'd7, 16'h0500);
         in_vld = 1'b1;
         step();
      end
      in_cmd = mk(8'h66, opcode_t'(4'h9), 16'd7, 16'h0501);
      cmd_full_r = 1'b0;
      step();
      in_vld = 1'b0;
      tests++;
      if (cmd_vld_r !== 1'b1 || cmd_r.uid !== 8'h60 || drop_vld_r !== 1'b1) begin
         failed++;
         $display("FAIL rstmid_pre: got vld=%b uid=%h drop=%b, expected vld=1 uid=60 drop=1", cmd_vld_r, cmd_r.uid, drop_vld_r);
      end
      #2 rst = 1'b0;
      #1;
      tests++;
      if (in_rdy !== 1'b0 || cmd_vld_r !== 1'b0 || cmd_r !== '0 || drop_vld_r !== 1'b0 ||
          drop_uid_r !== '0 || busy !== 1'b0) begin
         failed++;
         $display("FAIL rstmid_async: got rdy=%b vld=%b cmd=%h drop=%b uid=%h busy=%b, expected all 0",
                  in_rdy, cmd_vld_r, cmd_r, drop_vld_r, drop_uid_r, busy);
      end
      step();
      rst = 1'b1;
      issued_q.delete();
      repeat (3) step();
      tests++;
      if (busy !== 1'b0 || cmd_vld_r !== 1'b0 || in_rdy !== 1'b1 || issued_q.size() != 0) begin
         failed++;
         $display("FAIL rstmid_after: got busy=%b vld=%b rdy=%b issued=%0d, expected 0 0 1 0",
                  busy, cmd_vld_r, in_rdy, issued_q.size());
      end
   endtask

`ifdef OB_CMD_INGRESS_STATS_EN
   // Runs straight after a reset: 6 accepted (one illegal), peak occupancy 5,
   // then all 5 legal commands issue.
   task automatic test_stats();
      cmd_full_r = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_cmd = mk(uid_t'(8'h70 + i), (i == 2) ? opcode_t'(4'hE) : Op_QryBidAsk, 16'd1, 16'h0600);
         in_vld = 1'b1;
         step();
      end
      in_vld = 1'b0;
      cmd_full_r = 1'b0;
      repeat (DEPTH) step();
      tests++; if (stat_accepted_r !== CNT_W'(6)) begin failed++; $display("FAIL stat_accepted: got %0d, expected 6", stat_accepted_r); end
      tests++; if (stat_dropped_r !== CNT_W'(1)) begin failed++; $display("FAIL stat_dropped: got %0d, expected 1", stat_dropped_r); end
      tests++; if (stat_issued_r !== CNT_W'(5)) begin failed++; $display("FAIL stat_issued: got %0d, expected 5", stat_issued_r); end
      tests++; if (stat_hwm_r !== 4'd5) begin failed++; $display("FAIL stat_hwm: got %0d, expected 5", stat_hwm_r); end
   endtask
`endif

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_drop();
      test_toggle_bp();
      test_reset_mid();
`ifdef OB_CMD_INGRESS_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_ob_cmd_ingress

// File: doc/ob_cmd_ingress.md
Name: ob_cmd_ingress

Overview:
Command ingress stage directly upstream of the order book (ob). It accepts commands from the host over a valid/ready interface and buffers them in a FIFO. It screens out illegal opcodes, then issues at most one command per cycle to ob on the cmd_vld_r/cmd_r interface, throttled by ob's registered cmd_full_r. All ob-bound outputs are registered.

Parameters:
DEPTH, 8, FIFO entries; power of 2, at least 2
CNT_W, 32, width of the statistics counters (used only with the optional feature)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  reset; asynchronous assert, active-low (0 = in reset), deassert synchronised externally
in_vld  in  1  host command valid
in_cmd  in  $bits(ob_pkg::cmd_t)  host command (uid, opcode, oprand)
in_rdy  out  1  ingress can accept; equals !fifo_full, registered
cmd_vld_r  out  1  command valid to ob
cmd_r  out  $bits(ob_pkg::cmd_t)  command to ob
cmd_full_r  in  1  ob back-pressure, registered in ob
drop_vld_r  out  1  one-cycle pulse when an illegal command is discarded
drop_uid_r  out  $bits(ob_pkg::uid_t)  uid of the discarded command
busy  out  1  FIFO non-empty or cmd_vld_r high

Behaviour:
- Reset values (rst=0): FIFO empty, read/write pointers 0, in_rdy=0, cmd_vld_r=0, cmd_r='0, drop_vld_r=0, drop_uid_r='0, busy=0. in_rdy rises the first cycle after rst deasserts.
- Accept: a command is taken when in_vld & in_rdy on a clk edge. in_cmd must be held stable while in_vld=1 and in_rdy=0.
- Screening at accept:
  - Legal opcodes are Op_Nop, Op_QryBidAsk, Op_Buy and Op_Sell; these are written to the FIFO.
  - Any other opcode is not written. Next cycle drop_vld_r=1 and drop_uid_r=in_cmd.uid.
  - Op_Nop is forwarded, not dropped.
- Pointers are log2(DEPTH)+1 bits.
  - empty = (wp==rp).
  - full = MSBs differ and the lower bits are equal.
  - Pointers wrap naturally.
- Issue:
  - Condition: FIFO non-empty and cmd_full_r==0 at the edge.
  - On issue: pop the head, and next cycle cmd_vld_r=1 with cmd_r=head. Otherwise cmd_vld_r=0.
  - cmd_r holds its last value when cmd_vld_r=0.
  - Sustained throughput is 1 command per cycle.
- Latency: an accepted legal command into an empty FIFO, with cmd_full_r=0, appears on cmd_vld_r 2 cycles after the accept edge (write, then pop/register).
- cmd_full_r: ob asserts it with at least one free entry of slack, so one command issued in the same cycle full rises is legal. Ingress never issues on a cycle where it samples cmd_full_r=1.
- Simultaneous push and pop with the FIFO full: not allowed. in_rdy=0 when full, so no push occurs even if a pop frees space that cycle. in_rdy recomputes to 1 on the next cycle.
- Simultaneous push and pop with the FIFO empty: the pushed entry is not bypassed. It issues on the following cycle.
- Ordering: strict FIFO; commands are never reordered.
- Reset mid-operation: all queued commands are discarded. Outputs return to reset values immediately (asynchronously).

Optional Feature:
- Macro: OB_CMD_INGRESS_STATS_EN.
- When defined:
  - Adds outputs stat_accepted_r, stat_issued_r and stat_dropped_r, each CNT_W bits.
  - Each counts its events and saturates at all-ones rather than wrapping.
  - All three reset to 0.
  - Adds output stat_hwm_r, log2(DEPTH)+1 bits: the maximum FIFO occupancy since reset.
- When undefined: these ports and their logic are absent, and the core behaviour is identical.

Decomposition:
- ob_pkg (shared): cmd_t, opcode_t, uid_t, and a function is_legal_opcode(opcode_t).
- New localparams: OB_CMD_INGRESS_DEPTH_DFLT=8.
- Sub-module ob_cmd_fifo, a generic synchronous FIFO with push/pop/full/empty/occupancy outputs, parameterised by width and depth. Screening and issue logic stay in the top.

Test Plan:
- Reset, then push Op_Buy uid=5 qty=10 price=0x0123 with cmd_full_r=0 -> cmd_vld_r=1 exactly 2 cycles after accept; cmd_r.uid=5; oprand matches.
- Hold cmd_full_r=1 and push 8 commands (uid 1..8) -> in_rdy=0 after the 8th, no cmd_vld_r. Drop cmd_full_r -> uid 1..8 issue on 8 consecutive cycles, in order.
- Push an illegal opcode uid=0x3A between two Op_Sell -> drop_vld_r pulses once with drop_uid_r=0x3A; only the two Sells reach ob.
- Continuous push with cmd_full_r toggling every cycle -> no issue on any cycle where cmd_full_r was sampled 1; no command lost or duplicated (scoreboard).
- Fill 5 entries, then pulse rst low mid-stream -> all outputs at reset values immediately; after release, FIFO empty and busy=0.
- With OB_CMD_INGRESS_STATS_EN: 6 accepted, 1 dropped, 5 issued -> stat_accepted_r=6, stat_dropped_r=1, stat_issued_r=5; stat_hwm_r equals the peak occupancy.
